// File: rtl/sdram_device_model.sv
// Cycle-accurate single-data-rate SDRAM responder: command decode, per-bank row state,
// single-beat reads/writes with mode-register CAS latency, and sticky protocol error reporting.
module sdram_device_model #(
    parameter int unsigned SDRAM_ADDRESS_WIDTH         = 11,
    parameter int unsigned SDRAM_COLUMN_ADDRESS_WIDTH  = 8,
    parameter int unsigned SDRAM_BANK_BITS             = 2,
    parameter int unsigned MEM_BITS                    = 12,
    parameter int unsigned SDRAM_BANK_ACTIVATE_LATENCY = 2,
    parameter int unsigned SDRAM_PRECHARGE_LATENCY     = 2,
    parameter int unsigned SDRAM_AUTOREFRESH_LATENCY   = 3
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           sdram_ncs,
    input  logic                           sdram_ras,
    input  logic                           sdram_cas,
    input  logic                           sdram_nwe,
    input  logic [SDRAM_ADDRESS_WIDTH-1:0] sdram_address,
    input  logic [SDRAM_BANK_BITS-1:0]     sdram_ba,
    input  logic [3:0]                     sdram_dqm,
    input  logic [31:0]                    sdram_data_in,
    output logic [31:0]                    sdram_data_out,
    output logic                           sdram_data_oe,
    output logic                           error,
    output logic [2:0]                     error_code,
    output logic [15:0]                    refresh_count
);
    localparam int unsigned NumBanks = 2 ** SDRAM_BANK_BITS;
    localparam int unsigned Depth    = 2 ** MEM_BITS;
    localparam logic [7:0]  RcdInit  = 8'(SDRAM_BANK_ACTIVATE_LATENCY - 1);
    localparam logic [7:0]  RpInit   = 8'(SDRAM_PRECHARGE_LATENCY - 1);
    localparam logic [7:0]  RefInit  = 8'(SDRAM_AUTOREFRESH_LATENCY);

    typedef enum logic [2:0] {
        CmdNop, CmdActive, CmdRead, CmdWrite, CmdPrecharge, CmdRefresh, CmdLoadMode, CmdBurstStop
    } cmd_e;

    cmd_e                           cmd;
    logic [NumBanks-1:0]            open_q, open_d;
    logic [SDRAM_ADDRESS_WIDTH-1:0] row_q [NumBanks];
    logic [SDRAM_ADDRESS_WIDTH-1:0] row_d [NumBanks];
    logic [7:0]                     rcd_q [NumBanks];
    logic [7:0]                     rcd_d [NumBanks];
    logic [7:0]                     rp_q  [NumBanks];
    logic [7:0]                     rp_d  [NumBanks];
    logic [7:0]                     ref_blk_q, ref_blk_d;
    logic                           mode_loaded_q, mode_loaded_d, cl3_q, cl3_d;
    logic                           error_q, error_d;
    logic [2:0]                     code_q, code_d, viol;
    logic [15:0]                    count_q, count_d;
    logic                           rd_en, wr_en, rp_busy, a10;
    logic [MEM_BITS-1:0]            idx;
    logic [31:0]                    mem_q [Depth];
    logic [31:0]                    rd_masked;
    // Read pipeline: s1 holds the beat captured at the READ edge, s2 adds the third CL cycle.
    logic                           s1_vld_q, s1_cl3_q, s2_vld_q, oe_q;
    logic [31:0]                    s1_data_q, s2_data_q, dout_q;

    assign a10 = sdram_address[10];
    assign idx = MEM_BITS'({sdram_ba, row_q[sdram_ba],
                            sdram_address[SDRAM_COLUMN_ADDRESS_WIDTH-1:0]});

    always_comb begin
        cmd = CmdNop;
        if (!sdram_ncs) begin
            case ({sdram_ras, sdram_cas, sdram_nwe})
                3'b011:  cmd = CmdActive;
                3'b101:  cmd = CmdRead;
                3'b100:  cmd = CmdWrite;
                3'b010:  cmd = CmdPrecharge;
                3'b001:  cmd = CmdRefresh;
                3'b000:  cmd = CmdLoadMode;
                3'b110:  cmd = CmdBurstStop;
                default: cmd = CmdNop;
            endcase
        end
    end

    always_comb begin
        rp_busy = 1'b0;
        for (int b = 0; b < NumBanks; b++) rp_busy = rp_busy | (rp_q[b] != 8'd0);
        viol = 3'd0;
        if (cmd != CmdNop && ref_blk_q != 8'd0) begin
            viol = 3'd6;
        end else begin
            case (cmd)
                CmdLoadMode: begin
                    if (|open_q) viol = 3'd1;
                    else if (!(sdram_address[6:4] == 3'd2 || sdram_address[6:4] == 3'd3) ||
                             sdram_address[2:0] != 3'd0) viol = 3'd2;
                end
                CmdActive: begin
                    if (open_q[sdram_ba]) viol = 3'd3;
                    else if (rp_q[sdram_ba] != 8'd0) viol = 3'd6;
                end
                CmdRead, CmdWrite: begin
                    if (!mode_loaded_q) viol = 3'd4;
                    else if (!open_q[sdram_ba] || rcd_q[sdram_ba] != 8'd0) viol = 3'd5;
                end
                CmdRefresh: if (|open_q || rp_busy) viol = 3'd7;
                default: ;
            endcase
        end
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        for (int b = 0; b < NumBanks; b++) begin
            rcd_d[b] = (rcd_q[b] != 8'd0) ? rcd_q[b] - 8'd1 : 8'd0;
            rp_d[b]  = (rp_q[b] != 8'd0) ? rp_q[b] - 8'd1 : 8'd0;
        end
        ref_blk_d     = (ref_blk_q != 8'd0) ? ref_blk_q - 8'd1 : 8'd0;
        mode_loaded_d = mode_loaded_q;
        cl3_d         = cl3_q;
        count_d       = count_q;
        error_d       = error_q;
        code_d        = code_q;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
        if (viol != 3'd0) begin
            error_d = 1'b1;
            if (!error_q) code_d = viol;
        end else begin
            case (cmd)
                CmdLoadMode: begin
                    mode_loaded_d = 1'b1;
                    cl3_d         = sdram_address[4];
                end
                CmdActive: begin
                    open_d[sdram_ba] = 1'b1;
                    row_d[sdram_ba]  = sdram_address;
                    rcd_d[sdram_ba]  = RcdInit;
                end
                CmdRead, CmdWrite: begin
                    rd_en = (cmd == CmdRead);
                    wr_en = (cmd == CmdWrite);
                    if (a10) begin
                        open_d[sdram_ba] = 1'b0;
                        rp_d[sdram_ba]   = RpInit;
                    end
                end
                CmdPrecharge: begin
                    for (int b = 0; b < NumBanks; b++) begin
                        if (a10 || sdram_ba == SDRAM_BANK_BITS'(b)) begin
                            open_d[b] = 1'b0;
                            rp_d[b]   = RpInit;
                        end
                    end
                end
                CmdRefresh: begin
                    count_d   = count_q + 16'd1;
                    ref_blk_d = RefInit;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            rd_masked[8*i +: 8] = sdram_dqm[i] ? 8'h00 : mem_q[idx][8*i +: 8];
    end

    // Backing store is deliberately not reset so contents survive nreset.
    always_ff @(posedge clk) begin
        if (wr_en && nreset) begin
            for (int i = 0; i < 4; i++)
                if (!sdram_dqm[i]) mem_q[idx][8*i +: 8] <= sdram_data_in[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            open_q        <= '0;
            for (int b = 0; b < NumBanks; b++) begin
                row_q[b] <= '0;
                rcd_q[b] <= 8'd0;
                rp_q[b]  <= 8'd0;
            end
            ref_blk_q     <= 8'd0;
            mode_loaded_q <= 1'b0;
            cl3_q         <= 1'b0;
            error_q       <= 1'b0;
            code_q        <= 3'd0;
            count_q       <= 16'd0;
            s1_vld_q      <= 1'b0;
            s1_cl3_q      <= 1'b0;
            s1_data_q     <= 32'd0;
            s2_vld_q      <= 1'b0;
            s2_data_q     <= 32'd0;
            oe_q          <= 1'b0;
            dout_q        <= 32'd0;
        end else begin
            open_q        <= open_d;
            row_q         <= row_d;
            rcd_q         <= rcd_d;
            rp_q          <= rp_d;
            ref_blk_q     <= ref_blk_d;
            mode_loaded_q <= mode_loaded_d;
            cl3_q         <= cl3_d;
            error_q       <= error_d;
            code_q        <= code_d;
            count_q       <= count_d;
            s1_vld_q      <= rd_en;
            s1_cl3_q      <= cl3_q;
            s1_data_q     <= rd_masked;
            s2_vld_q      <= s1_vld_q && s1_cl3_q;
            s2_data_q     <= s1_data_q;
            if (s2_vld_q) begin
                oe_q   <= 1'b1;
                dout_q <= s2_data_q;
            end else if (s1_vld_q && !s1_cl3_q) begin
                oe_q   <= 1'b1;
                dout_q <= s1_data_q;
            end else begin
                oe_q   <= 1'b0;
                dout_q <= 32'd0;
            end
        end
    end

    assign sdram_data_out = dout_q;
    assign sdram_data_oe  = oe_q;
    assign error          = error_q;
    assign error_code     = code_q;
    assign refresh_count  = count_q;
endmodule
